// File: rtl/imem_load_ctrl_pkg.sv
// ============================================================================
// Module : imem_load_ctrl_pkg
// Brief  : Shared constants and load-sequencer state type for imem_load_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_load_ctrl_pkg;

    localparam int                cXLEN      = 32;
    localparam logic [cXLEN-1:0]  cEndMarker = 32'hDEADBEAF;
    localparam logic [cXLEN-1:0]  cNopInst   = 32'h00000013;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        WAIT_START = 3'd2,
        RUN        = 3'd3,
        ERROR      = 3'd4
    } tLoadState;

endpackage

`default_nettype wire

// File: rtl/imem_load_ctrl.sv
// ============================================================================
// Module : imem_load_ctrl
// Brief  : Boot-time instruction-memory loader; hands the RAM port to core
//          fetch once loading completes and a start request is seen.
//          Optional IMEM_CHECKSUM_EN adds oChecksum (XOR of written words).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter  int cDepth = 256,
    localparam int cAW    = $clog2(cDepth)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [cXLEN-1:0] iInst2Write,
    input  logic             iInstWen,
    input  logic             iStart,
    input  logic             iFetchReq,
    input  logic [cXLEN-1:0] iFetchAddr,
    output logic [cXLEN-1:0] oFetchInst,
    output logic             oFetchDv,
    output logic             oMemWen,
    output logic             oMemRen,
    output logic [cAW-1:0]   oMemAddr,
    output logic [cXLEN-1:0] oMemWData,
    input  logic [cXLEN-1:0] iMemRData,
    output logic             oCoreRun,
    output logic [cAW:0]     oInstCount,
    output logic             oOverflow,
    output logic             oMisalign
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [cXLEN-1:0] oChecksum
`endif
);

    tLoadState        state_q,     state_d;
    logic [cAW:0]     count_q,     count_d;
    logic             mem_wen_q,   mem_wen_d;
    logic [cAW-1:0]   wr_addr_q,   wr_addr_d;
    logic [cXLEN-1:0] wr_data_q,   wr_data_d;
    logic             overflow_q,  overflow_d;
    logic             fetch_dv_q,  fetch_dv_d;
    logic             fetch_nop_q, fetch_nop_d;
    logic             misalign_q,  misalign_d;

    logic             w_load_word;
    logic             w_full;
    logic             w_fetch_ok;
    logic             w_in_image;
    logic [cXLEN-3:0] w_word_idx;

    assign w_load_word = iInstWen && (iInst2Write != cEndMarker);
    assign w_full      = (count_q == (cAW+1)'(cDepth));
    assign w_word_idx  = iFetchAddr[cXLEN-1:2];
    assign w_in_image  = (w_word_idx < (cXLEN-2)'(count_q));
    // A write still draining in the first RUN cycle owns the port; fetch waits.
    assign w_fetch_ok  = (state_q == RUN) && !mem_wen_q && iFetchReq;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mem_wen_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE, LOAD: begin
                if (w_load_word) begin
                    if (w_full) begin
                        overflow_d = 1'b1;
                        state_d    = ERROR;
                    end else begin
                        mem_wen_d = 1'b1;
                        wr_addr_d = count_q[cAW-1:0];
                        wr_data_d = iInst2Write;
                        count_d   = count_q + 1'b1;
                        state_d   = LOAD;
                    end
                end else if (iInstWen) begin
                    state_d = WAIT_START;
                end
                if ((state_q == LOAD) && iStart && (state_d != ERROR)) begin
                    state_d = RUN;
                end
            end
            WAIT_START: begin
                if (iStart) begin
                    state_d = RUN;
                end
            end
            RUN, ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fetch_dv_d  = w_fetch_ok;
        fetch_nop_d = w_fetch_ok && !w_in_image;
        misalign_d  = w_fetch_ok && (iFetchAddr[1:0] != 2'b00);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mem_wen_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            overflow_q  <= 1'b0;
            fetch_dv_q  <= 1'b0;
            fetch_nop_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_wen_q   <= mem_wen_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            overflow_q  <= overflow_d;
            fetch_dv_q  <= fetch_dv_d;
            fetch_nop_q <= fetch_nop_d;
            misalign_q  <= misalign_d;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [cXLEN-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (mem_wen_d) begin
            checksum_d = checksum_q ^ iInst2Write;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign oChecksum = checksum_q;
`endif

    assign oMemRen    = w_fetch_ok && w_in_image;
    assign oMemWen    = mem_wen_q;
    assign oMemAddr   = oMemRen ? w_word_idx[cAW-1:0] : wr_addr_q;
    assign oMemWData  = wr_data_q;
    assign oFetchDv   = fetch_dv_q;
    assign oFetchInst = !fetch_dv_q ? '0 : (fetch_nop_q ? cNopInst : iMemRData);
    assign oCoreRun   = (state_q == RUN);
    assign oInstCount = count_q;
    assign oOverflow  = overflow_q;
    assign oMisalign  = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
// ============================================================================
// Module : tb_imem_load_ctrl
// Brief  : Directed self-checking bench for imem_load_ctrl with a 1-cycle RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_load_ctrl;

    localparam int          DEPTH  = 256;
    localparam logic [31:0] MARKER = 32'hDEADBEAF;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst2write;
    logic        inst_wen;
    logic        start;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_inst;
    logic        fetch_dv;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        core_run;
    logic [8:0]  inst_count;
    logic        overflow;
    logic        misalign;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [0:DEPTH-1];
    int          wr_cnt;
    int          addr_err;
    int          both_err = 0;

    always #5 clk = ~clk;

    imem_load_ctrl #(.cDepth(DEPTH)) dut (
        .iClk        (clk),
        .iRst        (rst),
        .iInst2Write (inst2write),
        .iInstWen    (inst_wen),
        .iStart      (start),
        .iFetchReq   (fetch_req),
        .iFetchAddr  (fetch_addr),
        .oFetchInst  (fetch_inst),
        .oFetchDv    (fetch_dv),
        .oMemWen     (mem_wen),
        .oMemRen     (mem_ren),
        .oMemAddr    (mem_addr),
        .oMemWData   (mem_wdata),
        .iMemRData   (mem_rdata),
        .oCoreRun    (core_run),
        .oInstCount  (inst_count),
        .oOverflow   (overflow),
        .oMisalign   (misalign)
`ifdef IMEM_CHECKSUM_EN
        ,
        .oChecksum   (checksum)
`endif
    );

    // Synchronous RAM plus a write log checking sequential addresses.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= 0;
            addr_err <= 0;
        end else begin
            if (mem_wen) begin
                ram[mem_addr] <= mem_wdata;
                if (32'(mem_addr) != wr_cnt) addr_err <= addr_err + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_ren) mem_rdata <= ram[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (mem_wen && mem_ren) both_err <= both_err + 1;
    end

    function automatic logic [31:0] word_a(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h111;
    endfunction

    function automatic logic [31:0] word_b(input int i);
        return 32'h5A00_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] xor_exp;
        rst        = 1'b1;
        inst2write = '0;
        inst_wen   = 1'b0;
        start      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;

        // Reset values
        #3;
        chk("rst_core_run", 32'(core_run), 0);
        chk("rst_count",    32'(inst_count), 0);
        chk("rst_mem_wen",  32'(mem_wen), 0);
        chk("rst_mem_ren",  32'(mem_ren), 0);
        chk("rst_fetch_dv", 32'(fetch_dv), 0);
        chk("rst_fetch_inst", fetch_inst, 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_misalign", 32'(misalign), 0);
        tick();
        rst = 1'b0;
        tick();

        // Start in IDLE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("idle_start_ignored", 32'(core_run), 0);

        // Load 10 words then marker
        xor_exp = '0;
        for (int i = 0; i < 10; i++) begin
            inst_wen   = 1'b1;
            inst2write = word_a(i);
            xor_exp    = xor_exp ^ word_a(i);
            tick();
        end
        inst2write = MARKER;
        tick();
        inst_wen = 1'b0;
        tick();
        tick();
        chk("load_count",    32'(inst_count), 10);
        chk("load_writes",   wr_cnt, 10);
        chk("load_addr_seq", addr_err, 0);
        chk("load_no_run",   32'(core_run), 0);
`ifdef IMEM_CHECKSUM_EN
        chk("checksum", checksum, xor_exp);
`endif

        // Writes in WAIT_START are ignored
        inst_wen   = 1'b1;
        inst2write = 32'h1234_5678;
        tick();
        inst_wen = 1'b0;
        tick();
        chk("wait_wr_ignored_cnt", 32'(inst_count), 10);
        chk("wait_wr_ignored_ram", wr_cnt, 10);

        start = 1'b1;
        #1;
        chk("run_before_edge", 32'(core_run), 0);
        tick();
        start = 1'b0;
        chk("run_after_start", 32'(core_run), 1);

        // Back-to-back fetch of words 0,1,2
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        #1;
        chk("fetch0_ren",  32'(mem_ren), 1);
        chk("fetch0_addr", 32'(mem_addr), 0);
        for (int k = 0; k < 3; k++) begin
            fetch_addr = 32'(4 * k);
            tick();
            chk("b2b_dv",   32'(fetch_dv), 1);
            chk("b2b_inst", fetch_inst, word_a(k));
        end
        fetch_req = 1'b0;
        tick();
        chk("b2b_dv_off", 32'(fetch_dv), 0);

        // Beyond loaded image
        fetch_req  = 1'b1;
        fetch_addr = 32'h40;
        #1;
        chk("oob_ren", 32'(mem_ren), 0);
        tick();
        fetch_req = 1'b0;
        chk("oob_dv",       32'(fetch_dv), 1);
        chk("oob_inst",     fetch_inst, NOP);
        chk("oob_misalign", 32'(misalign), 0);

        // Misaligned fetch
        fetch_req  = 1'b1;
        fetch_addr = 32'h6;
        tick();
        fetch_req = 1'b0;
        chk("mis_dv",   32'(fetch_dv), 1);
        chk("mis_inst", fetch_inst, word_a(1));
        chk("mis_flag", 32'(misalign), 1);
        tick();
        chk("mis_pulse_end", 32'(misalign), 0);

        // Image boundary: last word, first word past, beyond depth
        fetch_req  = 1'b1;
        fetch_addr = 32'h24;
        tick();
        chk("last_word", fetch_inst, word_a(9));
        fetch_addr = 32'h28;
        tick();
        chk("first_past", fetch_inst, NOP);
        fetch_addr = 32'h1000;
        tick();
        fetch_req = 1'b0;
        chk("past_depth",    fetch_inst, NOP);
        chk("past_depth_dv", 32'(fetch_dv), 1);

        // Write in RUN is ignored
        inst_wen   = 1'b1;
        inst2write = 32'h7777_7777;
        tick();
        inst_wen = 1'b0;
        tick();
        chk("run_wr_ignored", 32'(inst_count), 10);

        // Async reset mid-load at count 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            inst_wen   = 1'b1;
            inst2write = word_a(i + 20);
            tick();
        end
        inst_wen = 1'b0;
        chk("mid_count",   32'(inst_count), 5);
        chk("mid_mem_wen", 32'(mem_wen), 1);
        rst = 1'b1;
        #1;
        chk("async_mem_wen", 32'(mem_wen), 0);
        chk("async_count",   32'(inst_count), 0);
        chk("async_wdata",   mem_wdata, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reload; start arrives together with the last word
        inst_wen   = 1'b1;
        inst2write = word_b(0);
        tick();
        inst2write = word_b(1);
        tick();
        inst2write = word_b(2);
        start      = 1'b1;
        tick();
        inst_wen = 1'b0;
        start    = 1'b0;
        chk("reload_run",   32'(core_run), 1);
        chk("reload_count", 32'(inst_count), 3);
        tick();
        chk("reload_writes", wr_cnt, 3);
        chk("reload_addr",   addr_err, 0);
        fetch_req  = 1'b1;
        fetch_addr = 32'h8;
        tick();
        chk("reload_word2", fetch_inst, word_b(2));
        fetch_addr = 32'h0;
        tick();
        fetch_req = 1'b0;
        chk("reload_word0", fetch_inst, word_b(0));

        // Marker straight from IDLE: empty image, all NOPs
        do_reset();
        inst_wen   = 1'b1;
        inst2write = MARKER;
        tick();
        inst_wen = 1'b0;
        chk("empty_count", 32'(inst_count), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_run", 32'(core_run), 1);
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        #1;
        chk("empty_ren", 32'(mem_ren), 0);
        tick();
        fetch_req = 1'b0;
        chk("empty_nop", fetch_inst, NOP);

        // Overflow: DEPTH+1 words
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            inst_wen   = 1'b1;
            inst2write = 32'(i + 1);
            tick();
        end
        inst_wen = 1'b0;
        tick();
        tick();
        chk("ovf_flag",   32'(overflow), 1);
        chk("ovf_count",  32'(inst_count), DEPTH);
        chk("ovf_writes", wr_cnt, DEPTH);
        chk("ovf_addr",   addr_err, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ovf_no_run", 32'(core_run), 0);
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        tick();
        fetch_req = 1'b0;
        chk("ovf_fetch_dropped", 32'(fetch_dv), 0);
        chk("ovf_sticky",        32'(overflow), 1);

        chk("wen_ren_exclusive", both_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
